disp_scan: RTL

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/disp_scan.sv
// Four-digit multiplexed seven-segment scanner with per-slot anti-ghost blanking.
// Define DISP_SCAN_LZB_EN to enable leading-zero blanking.
module disp_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data,
  input  logic [3:0]  point,
  input  logic [3:0]  dig_mask,
  output logic [1:0]  s,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] TC = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BC = DW'(BLANK_CYC);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_s;
  logic [DW-1:0] r_div;
  logic [15:0]   r_snap_d;
  logic [3:0]    r_snap_p;
  logic [3:0]    r_hex;
  logic [3:0]    r_an;
  logic          r_dp;
  logic          r_frame;

  logic [1:0]    w_state_n;
  logic [1:0]    w_s_n;
  logic [DW-1:0] w_div_n;
  logic [15:0]   w_snap_d_n;
  logic [3:0]    w_snap_p_n;
  logic [3:0]    w_hex_n;
  logic [3:0]    w_an_n;
  logic          w_dp_n;
  logic          w_frame_n;
  logic          w_lit;
  logic          w_tc;

  assign w_tc = (r_div == TC);

  // Slot sequencing: divider, digit index and frame snapshot.
  always_comb begin
    w_s_n      = r_s;
    w_div_n    = r_div;
    w_snap_d_n = r_snap_d;
    w_snap_p_n = r_snap_p;
    if (!en) begin
      w_s_n   = 2'd0;
      w_div_n = '0;
    end else if (r_state == IDLE) begin
      w_s_n      = 2'd0;
      w_div_n    = '0;
      w_snap_d_n = data;
      w_snap_p_n = point;
    end else if (w_tc) begin
      w_div_n = '0;
      w_s_n   = r_s + 2'd1;
      if (r_s == 2'd3) begin
        w_snap_d_n = data;
        w_snap_p_n = point;
      end
    end else begin
      w_div_n = r_div + DW'(1);
    end
  end

  // Next FSM state follows the divider position within the slot.
  always_comb begin
    w_state_n = IDLE;
    if (en) begin
      w_state_n = (w_div_n < BC) ? BLANK : DRIVE;
    end
  end

  // 4:1 nibble mux on the next digit index.
  always_comb begin
    w_hex_n = w_snap_d_n[3:0];
    unique case (w_s_n)
      2'd0: w_hex_n = w_snap_d_n[3:0];
      2'd1: w_hex_n = w_snap_d_n[7:4];
      2'd2: w_hex_n = w_snap_d_n[11:8];
      2'd3: w_hex_n = w_snap_d_n[15:12];
    endcase
  end

`ifdef DISP_SCAN_LZB_EN
  logic [3:0] w_zero;
  logic       w_sup;

  assign w_zero[0] = (w_snap_d_n[3:0] == 4'h0);
  assign w_zero[1] = (w_snap_d_n[7:4] == 4'h0);
  assign w_zero[2] = (w_snap_d_n[11:8] == 4'h0);
  assign w_zero[3] = (w_snap_d_n[15:12] == 4'h0);

  // Digit k>0 goes dark when it and all higher digits are zero, unless its point is lit.
  always_comb begin
    w_sup = 1'b0;
    unique case (w_s_n)
      2'd0: w_sup = 1'b0;
      2'd1: w_sup = &w_zero[3:1];
      2'd2: w_sup = &w_zero[3:2];
      2'd3: w_sup = w_zero[3];
    endcase
    if (w_snap_p_n[w_s_n]) w_sup = 1'b0;
  end

  assign w_lit = (w_state_n == DRIVE) && dig_mask[w_s_n] && !w_sup;
`else
  assign w_lit = (w_state_n == DRIVE) && dig_mask[w_s_n];
`endif

  // Anode, point and frame-strobe decode for the upcoming cycle.
  always_comb begin
    w_an_n    = 4'hF;
    w_dp_n    = 1'b1;
    w_frame_n = 1'b0;
    if (w_lit) begin
      w_an_n = ~(4'b0001 << w_s_n);
      w_dp_n = ~w_snap_p_n[w_s_n];
    end
    if (en && (w_s_n == 2'd3) && (w_div_n == TC)) w_frame_n = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= 2'd0;
      r_div    <= '0;
      r_snap_d <= 16'h0000;
      r_snap_p <= 4'h0;
      r_hex    <= 4'h0;
      r_an     <= 4'hF;
      r_dp     <= 1'b1;
      r_frame  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_s      <= w_s_n;
      r_div    <= w_div_n;
      r_snap_d <= w_snap_d_n;
      r_snap_p <= w_snap_p_n;
      r_hex    <= w_hex_n;
      r_an     <= w_an_n;
      r_dp     <= w_dp_n;
      r_frame  <= w_frame_n;
    end
  end

  assign s     = r_s;
  assign hex   = r_hex;
  assign an    = r_an;
  assign dp    = r_dp;
  assign frame = r_frame;

endmodule
